// File: rtl/axi_llc_pkg.sv
// Shared LLC definitions used by the data-way arbiter and the cache units.
//   llc_cfg_t        : static LLC configuration record
//   cache_unit_e     : identifiers of the LLC cache units
//   way_arb_state_e  : way-arbiter lock state
//   way_arb_idx_t    : grant index for the default four-requester arbiter
//   beats_per_line() : beats in one cache line for a given configuration
package axi_llc_pkg;

  typedef struct packed {
    int unsigned SetAssociativity;
    int unsigned NumLines;
    int unsigned NumBlocks;
    int unsigned BlockSize;
    int unsigned TagLength;
    int unsigned IndexLength;
    int unsigned BlockOffsetLength;
    int unsigned ByteOffsetLength;
    int unsigned SPMLength;
  } llc_cfg_t;

  typedef enum logic [1:0] {
    READ_UNIT,
    WRITE_UNIT,
    EVICT_UNIT,
    REFILL_UNIT
  } cache_unit_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } way_arb_state_e;

  localparam int unsigned WAY_ARB_NUM_REQ = 4;
  typedef logic [$clog2(WAY_ARB_NUM_REQ)-1:0] way_arb_idx_t;

  function automatic int unsigned beats_per_line(input llc_cfg_t cfg);
    return 32'd1 << cfg.BlockOffsetLength;
  endfunction

endpackage

// File: rtl/axi_llc_way_arb_rr.sv
// Round-robin priority search: picks the first asserted valid at or after
// the pointer, wrapping around. Purely combinational.
//   valid_i : request valid per requester
//   ptr_i   : round-robin pointer (highest-priority index), must be < NumReq
//   idx_o   : selected index (0 when nothing is valid)
//   any_o   : at least one valid is asserted
module axi_llc_way_arb_rr #(
  parameter int unsigned NumReq = 4
) (
  input  logic [NumReq-1:0]         valid_i,
  input  logic [$clog2(NumReq)-1:0] ptr_i,
  output logic [$clog2(NumReq)-1:0] idx_o,
  output logic                      any_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam logic [IdxW:0] NumReqW = (IdxW + 1)'(NumReq);

  // cand_idx[k] is the requester index that has priority rank k this cycle.
  logic [NumReq-1:0][IdxW-1:0] cand_idx;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_cand
    logic [IdxW:0] sum;
    assign sum = {1'b0, ptr_i} + (IdxW + 1)'(gi);
    assign cand_idx[gi] = (sum >= NumReqW) ? IdxW'(sum - NumReqW) : IdxW'(sum);
  end

  // Scan from lowest priority upwards so the highest-priority hit wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (valid_i[cand_idx[i]]) begin
        idx_o = cand_idx[i];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_llc_way_arb.sv
// Data-way request arbiter. Round-robin between the cache units; a request
// flagged as burst keeps the port until a full line of beats is accepted.
// Zero-latency combinational mux with valid/ready handshake.
//   clk_i / rst_ni            : clock, synchronous active-low reset
//   req_i / req_valid_i       : per-requester payload and valid
//   req_burst_i               : first beat starts a full-line burst
//   req_ready_o               : per-requester accept
//   way_inp_o/_valid_o/_ready_i : muxed request towards the data ways
//   gnt_idx_o                 : current grant index (valid with way_inp_valid_o)
//   locked_o                  : burst lock active
//   gnt_cnt_o                 : accepted beats per requester (only with
//                               AXI_LLC_WAY_ARB_PERF_EN defined)
module axi_llc_way_arb
  import axi_llc_pkg::*;
#(
  parameter llc_cfg_t    Cfg       = llc_cfg_t'('0),
  parameter int unsigned NumReq    = 4,
  parameter type         way_inp_t = logic
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  way_inp_t                  req_i [NumReq],
  input  logic [NumReq-1:0]         req_valid_i,
  input  logic [NumReq-1:0]         req_burst_i,
  output logic [NumReq-1:0]         req_ready_o,
  output way_inp_t                  way_inp_o,
  output logic                      way_inp_valid_o,
  input  logic                      way_inp_ready_i,
  output logic [$clog2(NumReq)-1:0] gnt_idx_o,
`ifdef AXI_LLC_WAY_ARB_PERF_EN
  output logic [NumReq-1:0][31:0]   gnt_cnt_o,
`endif
  output logic                      locked_o
);

  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned Bol  = Cfg.BlockOffsetLength;
  localparam int unsigned CntW = (Bol > 0) ? Bol : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'((2 ** Bol) - 1);

  typedef logic [IdxW-1:0] idx_t;

  way_arb_state_e  state_reg;
  idx_t            rr_ptr_reg;
  idx_t            lock_idx_reg;
  logic [CntW-1:0] cnt_reg;

  idx_t rr_idx;
  logic rr_any;
  idx_t gnt_idx;
  logic gnt_valid;
  logic handshake;

  function automatic idx_t next_idx(input idx_t i);
    return (int'(i) == int'(NumReq) - 1) ? '0 : i + IdxW'(1);
  endfunction

  axi_llc_way_arb_rr #(
    .NumReq (NumReq)
  ) i_rr (
    .valid_i (req_valid_i),
    .ptr_i   (rr_ptr_reg),
    .idx_o   (rr_idx),
    .any_o   (rr_any)
  );

  // While locked only the burst owner may be served; a dropped valid simply
  // idles the port instead of letting anyone else in.
  assign gnt_idx   = (state_reg == ARB_LOCKED) ? lock_idx_reg : rr_idx;
  assign gnt_valid = (state_reg == ARB_LOCKED) ? req_valid_i[lock_idx_reg] : rr_any;
  assign handshake = gnt_valid & way_inp_ready_i;

  assign way_inp_o       = req_i[gnt_idx];
  assign way_inp_valid_o = gnt_valid;
  assign gnt_idx_o       = gnt_idx;
  assign locked_o        = (state_reg == ARB_LOCKED);

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_ready
    assign req_ready_o[gi] = handshake & (gnt_idx == idx_t'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg    <= ARB_IDLE;
      rr_ptr_reg   <= '0;
      lock_idx_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      unique case (state_reg)
        ARB_IDLE: begin
          if (handshake) begin
            // A one-beat line needs no lock; treat it like a plain request.
            if (req_burst_i[gnt_idx] && (Bol > 0)) begin
              state_reg    <= ARB_LOCKED;
              lock_idx_reg <= gnt_idx;
              cnt_reg      <= CntW'(1);
            end else begin
              rr_ptr_reg <= next_idx(gnt_idx);
            end
          end
        end
        ARB_LOCKED: begin
          if (handshake) begin
            if (cnt_reg == LastBeat) begin
              state_reg  <= ARB_IDLE;
              cnt_reg    <= '0;
              rr_ptr_reg <= next_idx(lock_idx_reg);
            end else begin
              cnt_reg <= cnt_reg + CntW'(1);
            end
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

`ifdef AXI_LLC_WAY_ARB_PERF_EN
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
    logic [31:0] gnt_cnt_reg;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        gnt_cnt_reg <= '0;
      end else if (req_ready_o[gi] && (gnt_cnt_reg != '1)) begin
        gnt_cnt_reg <= gnt_cnt_reg + 32'd1;
      end
    end
    assign gnt_cnt_o[gi] = gnt_cnt_reg;
  end
`endif

endmodule

// File: tb/tb_axi_llc_way_arb.sv
// Bench for axi_llc_way_arb: directed scenarios followed by random traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_axi_llc_way_arb;
  import axi_llc_pkg::*;

  localparam int N     = 4;
  localparam int BEATS = 4;
  localparam llc_cfg_t TbCfg = '{BlockOffsetLength: 32'd2, default: '0};

  typedef logic [15:0] pay_t;

  logic           clk = 1'b0;
  logic           rst_ni;
  pay_t           req [N];
  logic [N-1:0]   valid;
  logic [N-1:0]   burst;
  logic [N-1:0]   ready_o;
  pay_t           way_o;
  logic           way_v;
  logic           way_r;
  logic [1:0]     gnt;
  logic           locked;
`ifdef AXI_LLC_WAY_ARB_PERF_EN
  logic [N-1:0][31:0] gnt_cnt;
`endif

  always #5 clk = ~clk;

  axi_llc_way_arb #(
    .Cfg       (TbCfg),
    .NumReq    (N),
    .way_inp_t (pay_t)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .req_i           (req),
    .req_valid_i     (valid),
    .req_burst_i     (burst),
    .req_ready_o     (ready_o),
    .way_inp_o       (way_o),
    .way_inp_valid_o (way_v),
    .way_inp_ready_i (way_r),
    .gnt_idx_o       (gnt),
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    .gnt_cnt_o       (gnt_cnt),
`endif
    .locked_o        (locked)
  );

  int tests = 0;
  int fails = 0;

  // Reference model state: pointer, burst owner, beats already taken.
  int m_ptr = 0;
  int m_locked = 0;
  int m_lock_idx = 0;
  int m_done = 0;
  int unsigned m_cnt [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_locked = 0; m_lock_idx = 0; m_done = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then return 1 time unit later so the caller can drive new inputs.
  // xg/xv/xl are extra explicit expectations (-1 = none).
  task automatic tick(input string tag, input int xg, input int xv, input int xl);
    int g;
    bit v;
    logic [N-1:0] er;
    @(negedge clk);
    g = 0;
    v = 1'b0;
    if (m_locked != 0) begin
      g = m_lock_idx;
      v = valid[g];
    end else begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (m_ptr + k) % N;
        if (!v && valid[r]) begin
          v = 1'b1;
          g = r;
        end
      end
    end
    er = (v && way_r) ? N'(1 << g) : '0;
    chk({tag, "_valid"}, 32'(way_v), 32'(v));
    chk({tag, "_ready"}, 32'(ready_o), 32'(er));
    chk({tag, "_locked"}, 32'(locked), 32'(m_locked));
    if (v) begin
      chk({tag, "_gnt"}, 32'(gnt), 32'(g));
      chk({tag, "_payload"}, 32'(way_o), 32'(req[g]));
    end
    if (xg >= 0) chk({tag, "_dir_gnt"}, 32'(gnt), 32'(xg));
    if (xv >= 0) chk({tag, "_dir_valid"}, 32'(way_v), 32'(xv));
    if (xl >= 0) chk({tag, "_dir_locked"}, 32'(locked), 32'(xl));
    @(posedge clk);
    if (!rst_ni) begin
      model_reset();
    end else if (v && way_r) begin
      $display("[TB] %s beat gnt=%0d data=%04h locked=%0d", tag, g, req[g], m_locked);
      m_cnt[g]++;
      if (m_locked != 0) begin
        m_done++;
        if (m_done == BEATS) begin
          m_locked = 0;
          m_done = 0;
          m_ptr = (m_lock_idx + 1) % N;
        end
      end else if (burst[g]) begin
        m_locked = 1;
        m_lock_idx = g;
        m_done = 1;
      end else begin
        m_ptr = (g + 1) % N;
      end
    end
    #1;
  endtask

  initial begin
    rst_ni = 1'b0;
    valid  = '0;
    burst  = '0;
    way_r  = 1'b1;
    for (int i = 0; i < N; i++) req[i] = pay_t'(16'h1000 * (i + 1) + i);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Reset state: nothing valid, no grant, not locked.
    tick("reset_idle", -1, 0, 0);
    chk("reset_ready", 32'(ready_o), 32'd0);

    // Three plain requesters rotate, requester 2 never appears.
    valid = 4'b1011;
    tick("rr0", 0, 1, 0);
    tick("rr1", 1, 1, 0);
    tick("rr2", 3, 1, 0);
    tick("rr3", 0, 1, 0);
    tick("rr4", 1, 1, 0);
    tick("rr5", 3, 1, 0);

    // Move pointer to 2, then a 4-beat burst from 2 while 0 waits.
    valid = 4'b0010;
    tick("pre_burst", 1, 1, 0);
    valid = 4'b0101;
    burst = 4'b0100;
    tick("burst_b1", 2, 1, 0);
    tick("burst_b2", 2, 1, 1);
    tick("burst_b3", 2, 1, 1);
    tick("burst_b4", 2, 1, 1);
    burst = 4'b0000;
    tick("burst_after", 0, 1, 0);

    // Burst owner 1 drops valid mid-burst; requester 0 must keep waiting.
    valid = 4'b0011;
    burst = 4'b0010;
    tick("drop_b1", 1, 1, 0);
    tick("drop_b2", 1, 1, 1);
    valid = 4'b0001;
    tick("drop_gap0", -1, 0, 1);
    tick("drop_gap1", -1, 0, 1);
    tick("drop_gap2", -1, 0, 1);
    valid = 4'b0011;
    tick("drop_b3", 1, 1, 1);
    tick("drop_b4", 1, 1, 1);
    burst = 4'b0000;
    tick("drop_after", 0, 1, 0);

    // Back-pressure: valid and payload held, no accept.
    valid = 4'b0001;
    way_r = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick("stall", 0, 1, 0);
      chk("stall_ready0", 32'(ready_o[0]), 32'd0);
    end
    way_r = 1'b1;
    tick("stall_release", 0, 1, 0);

    // Reset in the middle of a burst clears the lock.
    valid = 4'b0010;
    burst = 4'b0010;
    tick("rst_b1", 1, 1, 0);
    tick("rst_b2", 1, 1, 1);
    rst_ni = 1'b0;
    tick("rst_assert", -1, 1, 1);
    rst_ni = 1'b1;
    valid = 4'b0011;
    burst = 4'b0000;
    tick("rst_after0", 0, 1, 0);
    tick("rst_after1", 1, 1, 0);

    // Per-requester beat counters.
`ifdef AXI_LLC_WAY_ARB_PERF_EN
    rst_ni = 1'b0;
    valid = '0;
    tick("perf_rst", -1, 0, -1);
    rst_ni = 1'b1;
    valid = 4'b1000;
    for (int c = 0; c < 10; c++) tick("perf", 3, 1, 0);
    @(negedge clk);
    chk("perf_cnt0", gnt_cnt[0], 32'd0);
    chk("perf_cnt1", gnt_cnt[1], 32'd0);
    chk("perf_cnt2", gnt_cnt[2], 32'd0);
    chk("perf_cnt3", gnt_cnt[3], 32'd10);
    @(posedge clk);
    #1;
`endif

    // Random traffic, including bursts, back-pressure and occasional resets.
    for (int c = 0; c < 400; c++) begin
      valid  = N'($urandom_range(0, 15));
      burst  = N'($urandom & $urandom);
      way_r  = ($urandom_range(0, 3) != 0);
      rst_ni = ($urandom_range(0, 99) != 0);
      for (int i = 0; i < N; i++) req[i] = pay_t'($urandom);
      tick("rand", -1, -1, -1);
    end
    rst_ni = 1'b1;

`ifdef AXI_LLC_WAY_ARB_PERF_EN
    @(negedge clk);
    for (int i = 0; i < N; i++) chk("rand_perf_cnt", gnt_cnt[i], m_cnt[i]);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
